// File: rtl/mac_pkg.sv
// Shared types and constants for the carry-save MAC accumulator.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ACC_W_MIN = 16;
  localparam int ACC_W_MAX = 32;
  localparam int PROD_W    = 16;

endpackage

// File: rtl/eight_x_eight_mul.sv
// Unsigned 8x8 carry-save array multiplier: rows are compressed 3:2 into
// sum/carry vectors and resolved by one final carry-propagate add.
module eight_x_eight_mul
  import mac_pkg::*;
(
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] sum_v;
  logic [PROD_W-1:0] carry_v;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] nsum;
  logic [PROD_W-1:0] ncarry;

  // Carries shifted past bit 15 are multiples of 2^16 and drop out exactly.
  always_comb begin
    sum_v   = '0;
    carry_v = '0;
    pp      = '0;
    nsum    = '0;
    ncarry  = '0;
    for (int i = 0; i < 8; i++) begin
      pp      = {8'b0, (a_i & {8{b_i[i]}})} << i;
      nsum    = sum_v ^ carry_v ^ pp;
      ncarry  = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = nsum;
      carry_v = ncarry;
    end
  end

  assign p_o = sum_v + carry_v;

endmodule

// File: rtl/csa_mac_accumulator.sv
// Streaming multiply-accumulate: operand register -> 8x8 multiplier ->
// product register -> wide accumulator, framed by start/len and a result handshake.
module csa_mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy,
  output state_t           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and ready only reflects free capacity.

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [7:0]        op_a_q, op_a_d;
  logic [7:0]        op_b_q, op_b_d;
  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [PROD_W-1:0] mul_p;
  logic [ACC_W:0]    acc_sum;
  logic              job_start;
  logic              issue_fire;
  logic              last_acc;

  eight_x_eight_mul u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  assign job_start  = (state_q == ST_IDLE) && start;
  assign issue_fire = in_valid && in_ready;
  assign last_acc   = s2_valid_q && (acc_cnt_q == len_q - LEN_W'(1));
  assign acc_sum    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_acc) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_RUN) && (issued_q < len_q);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    state_dbg = state_q;
  end

  // Datapath next-state; the pipeline is always empty outside RUN.
  always_comb begin
    len_d      = len_q;
    issued_d   = issued_q;
    acc_cnt_d  = acc_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    s1_valid_d = issue_fire;
    prod_d     = prod_q;
    s2_valid_d = s1_valid_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    if (job_start) begin
      acc_d      = '0;
      ovf_d      = 1'b0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      if (len != '0) begin
        len_d     = len;
        issued_d  = '0;
        acc_cnt_d = '0;
      end
    end else begin
      if (issue_fire) begin
        op_a_d   = a;
        op_b_d   = b;
        issued_d = issued_q + LEN_W'(1);
      end
      if (s1_valid_q) prod_d = mul_p;
      if (s2_valid_q) begin
        acc_d     = acc_sum[ACC_W-1:0];
        ovf_d     = ovf_q | acc_sum[ACC_W];
        acc_cnt_d = acc_cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      acc_cnt_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      issued_q   <= issued_d;
      acc_cnt_q  <= acc_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s1_valid_q <= s1_valid_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule
